// File: rtl/mbus_interconnect.sv
// Memory-bus interconnect: registered IDLE/ACCESS/DONE transaction FSM between the CPU
// master port and up to 16 slaves, with address-code decode, wait states, timeout and error count.
module mbus_interconnect #(
  parameter int unsigned                    WIDTH       = 32,
  parameter int unsigned                    NSLAVES     = 5,
  parameter int unsigned                    SEL_LSB     = 12,
  parameter int unsigned                    SEL_BITS    = 4,
  parameter logic [NSLAVES*SEL_BITS-1:0]    SLAVE_CODES = {4'hF, 4'hE, 4'hD, 4'hC, 4'h0},
  parameter int unsigned                    TIMEOUT     = 15,
  parameter logic [WIDTH-1:0]               ERR_VALUE   = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_req,
  input  logic [WIDTH-1:0]           m_addr,
  input  logic [WIDTH-1:0]           m_wdata,
  input  logic                       m_wen,
  output logic [WIDTH-1:0]           m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic                       m_busy,
  output logic [NSLAVES-1:0]         s_cs,
  output logic [WIDTH-1:0]           s_addr,
  output logic [WIDTH-1:0]           s_wdata,
  output logic                       s_wen,
  input  logic [NSLAVES*WIDTH-1:0]   s_rdata,
  input  logic [NSLAVES-1:0]         s_ready,
  output logic [7:0]                 err_count
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic                 wen_q, wen_d;
  logic [NSLAVES-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NSLAVES-1:0]   dec_sel;
  logic                 dec_hit;
  logic                 sel_rdy;
  logic [WIDTH-1:0]     sel_rdata;

  // Address decode (lowest matching index wins) and selected-slave ready/rdata mux
  always_comb begin
    dec_sel   = '0;
    dec_hit   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLAVES; i++) begin
      if (!dec_hit && (m_addr[SEL_LSB +: SEL_BITS] == SLAVE_CODES[i*SEL_BITS +: SEL_BITS])) begin
        dec_sel[i] = 1'b1;
        dec_hit    = 1'b1;
      end
      if (sel_q[i]) sel_rdata = sel_rdata | s_rdata[i*WIDTH +: WIDTH];
    end
    sel_rdy = |(sel_q & s_ready);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      sel_q   <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    sel_d   = sel_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wen_d   = m_wen;
          if (dec_hit) begin
            sel_d   = dec_sel;
            wait_d  = '0;
            state_d = ACCESS;
          end else begin
            rdata_d = ERR_VALUE;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        // Ready on the timeout cycle takes priority over the timeout
        if (sel_rdy) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (wait_q == TO_LAST)) begin
          rdata_d = ERR_VALUE;
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (err_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and latched registers
  always_comb begin
    m_busy = (state_q != IDLE);
    s_cs   = (state_q == ACCESS) ? sel_q : '0;
    s_wen  = (state_q == ACCESS) && wen_q;
  end

  assign m_rdata   = rdata_q;
  assign m_ready   = ready_q;
  assign m_err     = err_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_mbus_interconnect.sv
// Directed bench for mbus_interconnect: decode, wait states, timeout, ready-vs-timeout race,
// decode errors, error-count saturation and reset during an access.
module tb_mbus_interconnect;

  logic         clk;
  logic         reset;
  logic         m_req;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic         m_wen;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;
  logic         m_busy;
  logic [4:0]   s_cs;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         s_wen;
  logic [159:0] s_rdata;
  logic [4:0]   s_ready;
  logic [7:0]   err_count;

  int total = 0;
  int bad   = 0;
  int ncs;
  int rcyc;

  mbus_interconnect dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .m_busy(m_busy),
    .s_cs(s_cs), .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen),
    .s_rdata(s_rdata), .s_ready(s_ready), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w);
    m_req = 1'b1; m_addr = a; m_wdata = d; m_wen = w;
    tick();
    m_req = 1'b0;
  endtask

  // Called in cycle 1 after issue; counts cycles with s_cs==cs and finds the m_ready cycle.
  // If raise_at > 0, sets s_ready[slot] during that cycle.
  task automatic run(input logic [4:0] cs, input int raise_at, input int slot,
                     output int n_cs, output int rdy_at);
    n_cs = 0; rdy_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (s_cs === cs) n_cs++;
      if (m_ready === 1'b1) begin
        rdy_at = c;
        break;
      end
      if (c == raise_at) s_ready[slot] = 1'b1;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_wen = 1'b0;
    s_ready = 5'b11111;
    s_rdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h12345678};
    #2;
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_cs", 32'(s_cs), 32'd0);
    chk("rst_ready", 32'(m_ready), 32'd0);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_saddr", s_addr, 32'h0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Zero-wait read of memory (slave 0)
    issue(32'h0000_0010, 32'h0, 1'b0);
    chk("rd0_cs_c1", 32'(s_cs), 32'h01);
    chk("rd0_wen_c1", 32'(s_wen), 32'd0);
    chk("rd0_busy_c1", 32'(m_busy), 32'd1);
    chk("rd0_saddr", s_addr, 32'h0000_0010);
    chk("rd0_ready_c1", 32'(m_ready), 32'd0);
    tick();
    chk("rd0_ready_c2", 32'(m_ready), 32'd1);
    chk("rd0_cs_c2", 32'(s_cs), 32'h00);
    chk("rd0_rdata", m_rdata, 32'h1234_5678);
    chk("rd0_err", 32'(m_err), 32'd0);
    tick();
    chk("rd0_ready_c3", 32'(m_ready), 32'd0);
    chk("rd0_busy_c3", 32'(m_busy), 32'd0);

    // Write to slave 4 with three wait states; other slaves ready but ignored
    s_ready = 5'b01111;
    issue(32'h0000_F001, 32'h0000_00A5, 1'b1);
    chk("wr4_saddr", s_addr, 32'h0000_F001);
    chk("wr4_swdata", s_wdata, 32'h0000_00A5);
    chk("wr4_swen", 32'(s_wen), 32'd1);
    run(5'b10000, 4, 4, ncs, rcyc);
    chk("wr4_cs_cycles", 32'(ncs), 32'd4);
    chk("wr4_ready_at", 32'(rcyc), 32'd5);
    chk("wr4_err", 32'(m_err), 32'd0);
    chk("wr4_swen_done", 32'(s_wen), 32'd0);
    tick();
    chk("wr4_errcnt", 32'(err_count), 32'd0);

    // Decode error on unmapped code 5
    s_ready = 5'b11111;
    issue(32'h0000_5000, 32'h0, 1'b0);
    chk("dec_ready_c1", 32'(m_ready), 32'd1);
    chk("dec_cs", 32'(s_cs), 32'd0);
    chk("dec_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("dec_err", 32'(m_err), 32'd1);
    tick();
    chk("dec_errcnt", 32'(err_count), 32'd1);
    chk("dec_busy", 32'(m_busy), 32'd0);

    // Timeout on slave 1 with ready stuck low
    s_ready = 5'b11101;
    issue(32'h0000_C000, 32'h0, 1'b0);
    run(5'b00010, 0, 1, ncs, rcyc);
    chk("to_cs_cycles", 32'(ncs), 32'd15);
    chk("to_ready_at", 32'(rcyc), 32'd16);
    chk("to_err", 32'(m_err), 32'd1);
    chk("to_rdata", m_rdata, 32'hDEAD_BEEF);
    tick();
    chk("to_errcnt", 32'(err_count), 32'd2);

    // Ready on the last timeout cycle of slave 2: ready wins
    s_ready = 5'b11011;
    issue(32'h0000_D008, 32'h0, 1'b0);
    run(5'b00100, 15, 2, ncs, rcyc);
    chk("race_cs_cycles", 32'(ncs), 32'd15);
    chk("race_ready_at", 32'(rcyc), 32'd16);
    chk("race_err", 32'(m_err), 32'd0);
    chk("race_rdata", m_rdata, 32'h2222_2222);
    tick();
    chk("race_errcnt", 32'(err_count), 32'd2);

    // 300 decode errors saturate the counter
    s_ready = 5'b11111;
    for (int k = 0; k < 300; k++) begin
      issue(32'h0000_7000, 32'h0, 1'b0);
      tick();
    end
    chk("sat_errcnt", 32'(err_count), 32'd255);

    // Reset asserted in ACCESS cycle 2 of a waited read
    s_ready = 5'b11110;
    issue(32'h0000_0020, 32'h0, 1'b0);
    tick();
    chk("ra_cs_c2", 32'(s_cs), 32'h01);
    reset = 1'b1;
    #1;
    chk("ra_busy", 32'(m_busy), 32'd0);
    chk("ra_cs", 32'(s_cs), 32'd0);
    chk("ra_errcnt", 32'(err_count), 32'd0);
    chk("ra_rdata", m_rdata, 32'h0);
    chk("ra_saddr", s_addr, 32'h0);
    tick();
    chk("ra_ready_held", 32'(m_ready), 32'd0);
    reset = 1'b0;
    s_ready = 5'b11111;
    tick();
    chk("ra_ready_after", 32'(m_ready), 32'd0);
    issue(32'h0000_E004, 32'h0, 1'b0);
    run(5'b01000, 0, 3, ncs, rcyc);
    chk("post_cs_cycles", 32'(ncs), 32'd1);
    chk("post_ready_at", 32'(rcyc), 32'd2);
    chk("post_rdata", m_rdata, 32'h3333_3333);
    chk("post_err", 32'(m_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
